rf_write_arbiter: RTL and testbench

- Shares the physical register file's two write ports among NUM_REQ completing functional units (ALU0, ALU1, LSU, MUL/DIV) using round-robin selection.
- Uses a valid/ready handshake per requester. Grants up to two writes per cycle into a registered output stage that drives the register file write ports directly.
- Guarantees that the two ports never carry the same nonzero destination in one cycle, so write order within a cycle never matters.

---
 rtl/rf_write_arbiter_if.sv | 35 +++
 rtl/rf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between completing functional units and the register file write arbiter.
// Carries the per-requester valid/ready handshake and the two registered write ports.
interface rf_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_P_REGS = 64,
  parameter int unsigned WORD_SIZE  = 32
);
  localparam int unsigned PW = $clog2(NUM_P_REGS);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*PW-1:0]        req_dest;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;

  logic                 reg_write0;
  logic [PW-1:0]        dest0;
  logic [WORD_SIZE-1:0] word0;
  logic                 reg_write1;
  logic [PW-1:0]        dest1;
  logic [WORD_SIZE-1:0] word1;

  // Requester / register-file side of the bus.
  modport master (
    output req_valid, req_dest, req_data,
    input  req_ready,
    input  reg_write0, dest0, word0, reg_write1, dest1, word1
  );

  // Arbiter side of the bus.
  modport slave (
    input  req_valid, req_dest, req_data,
    output req_ready,
    output reg_write0, dest0, word0, reg_write1, dest1, word1
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing two register file write ports among NUM_REQ writeback sources.
// Grants up to two requesters per cycle with distinct nonzero destinations; outputs are registered.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_P_REGS = 64,
  parameter int unsigned WORD_SIZE  = 32,
  localparam int unsigned PW        = $clog2(NUM_P_REGS),
  localparam int unsigned RW        = $clog2(NUM_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              wb_stall_i,
  rf_write_arbiter_if.slave wb_if,
  output logic [RW-1:0]     rr_ptr_o
);

  logic [PW-1:0]        dest_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] data_arr [NUM_REQ];

  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [RW:0]   scan_sum;
  logic [RW-1:0] scan_idx;
  logic [RW-1:0] sel0, sel1, last_sel;
  logic          found0, found1;
  logic          grant_en, grant0, grant1;
  logic [NUM_REQ-1:0] ready_d;

  logic                 we0_q, we0_d, we1_q, we1_d;
  logic [PW-1:0]        dest0_q, dest0_d, dest1_q, dest1_d;
  logic [WORD_SIZE-1:0] word0_q, word0_d, word1_q, word1_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dest_arr[i] = wb_if.req_dest[i*PW +: PW];
      data_arr[i] = wb_if.req_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Scan from rr_ptr with wrap; slot 1 skips requesters aliasing slot 0's nonzero destination.
  always_comb begin
    found0   = 1'b0;
    found1   = 1'b0;
    sel0     = '0;
    sel1     = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (scan_sum >= (RW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (RW+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[RW-1:0];
      if (wb_if.req_valid[scan_idx]) begin
        if (!found0) begin
          found0 = 1'b1;
          sel0   = scan_idx;
        end else if (!found1 && ((dest_arr[scan_idx] != dest_arr[sel0]) ||
                                 (dest_arr[scan_idx] == '0))) begin
          found1 = 1'b1;
          sel1   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant_en = !flush_i && !wb_stall_i;
    grant0   = grant_en && found0;
    grant1   = grant_en && found1;

    ready_d = '0;
    if (grant0) ready_d[sel0] = 1'b1;
    if (grant1) ready_d[sel1] = 1'b1;

    last_sel = grant1 ? sel1 : sel0;
    rr_ptr_d = rr_ptr_q;
    if (grant0) begin
      rr_ptr_d = (last_sel == RW'(NUM_REQ - 1)) ? '0 : last_sel + RW'(1);
    end

    // p0 is never written: a dest-0 grant still consumes its slot but keeps the enable low.
    we0_d   = grant0 && (dest_arr[sel0] != '0);
    dest0_d = grant0 ? dest_arr[sel0] : '0;
    word0_d = grant0 ? data_arr[sel0] : '0;
    we1_d   = grant1 && (dest_arr[sel1] != '0);
    dest1_d = grant1 ? dest_arr[sel1] : '0;
    word1_d = grant1 ? data_arr[sel1] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= '0;
      we0_q    <= 1'b0;
      dest0_q  <= '0;
      word0_q  <= '0;
      we1_q    <= 1'b0;
      dest1_q  <= '0;
      word1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we0_q    <= we0_d;
      dest0_q  <= dest0_d;
      word0_q  <= word0_d;
      we1_q    <= we1_d;
      dest1_q  <= dest1_d;
      word1_q  <= word1_d;
    end
  end

  assign wb_if.req_ready  = rst_n_i ? ready_d : '0;
  assign wb_if.reg_write0 = we0_q;
  assign wb_if.dest0      = dest0_q;
  assign wb_if.word0      = word0_q;
  assign wb_if.reg_write1 = we1_q;
  assign wb_if.dest1      = dest1_q;
  assign wb_if.word1      = word1_q;
  assign rr_ptr_o         = rr_ptr_q;

  a_no_dup_dest: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(wb_if.reg_write0 && wb_if.reg_write1 && (wb_if.dest0 == wb_if.dest1)));

  a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ((wb_if.req_ready & ~wb_if.req_valid) == '0));

  a_at_most_two: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ($countones(wb_if.req_ready) <= 2));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: requester model predicts grants and writes,
// monitors compare ready mid-cycle and the registered write ports after each edge.
module tb_rf_write_arbiter;
  localparam int N  = 4;
  localparam int PW = 6;
  localparam int W  = 32;

  typedef struct packed {
    logic          we0;
    logic [PW-1:0] d0;
    logic [W-1:0]  w0;
    logic          we1;
    logic [PW-1:0] d1;
    logic [W-1:0]  w1;
    logic [1:0]    rr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       stall;
  logic [1:0] rr_ptr;

  rf_write_arbiter_if #(.NUM_REQ(N), .NUM_P_REGS(64), .WORD_SIZE(W)) bus ();

  rf_write_arbiter #(.NUM_REQ(N), .NUM_P_REGS(64), .WORD_SIZE(W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .wb_stall_i (stall),
    .wb_if      (bus),
    .rr_ptr_o   (rr_ptr)
  );

  always #5 clk = ~clk;

  // Requester state and model round-robin pointer.
  logic          pv [N];
  logic [PW-1:0] pd [N];
  logic [W-1:0]  pw [N];
  int            m_rr;

  exp_t         wr_q  [$];
  logic [N-1:0] rdy_q [$];
  exp_t         mon_e;
  logic [N-1:0] mon_r;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = pv[i];
      bus.req_dest[i*PW +: PW]  = pd[i];
      bus.req_data[i*W +: W]    = pw[i];
    end
  endtask

  // Drive current requests, predict this cycle's grants, then advance to the next cycle.
  task automatic step(input logic s, input logic f);
    int   slots [$];
    int   j;
    exp_t e;
    logic [N-1:0] r;
    stall = s;
    flush = f;
    drive();
    slots = {};
    if (!s && !f) begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (pv[j]) begin
          if (slots.size() == 0) slots.push_back(j);
          else if (slots.size() == 1 && (pd[j] != pd[slots[0]] || pd[j] == 0)) slots.push_back(j);
        end
      end
    end
    r = '0;
    e = '0;
    foreach (slots[q]) r[slots[q]] = 1'b1;
    if (slots.size() > 0) begin
      e.we0 = (pd[slots[0]] != 0);
      e.d0  = pd[slots[0]];
      e.w0  = pw[slots[0]];
      m_rr  = (slots[slots.size()-1] + 1) % N;
    end
    if (slots.size() > 1) begin
      e.we1 = (pd[slots[1]] != 0);
      e.d1  = pd[slots[1]];
      e.w1  = pw[slots[1]];
    end
    e.rr = 2'(m_rr);
    foreach (slots[q]) pv[slots[q]] = 1'b0;
    rdy_q.push_back(r);
    wr_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int i, input int d, input logic [W-1:0] w);
    pv[i] = 1'b1;
    pd[i] = PW'(d);
    pw[i] = w;
  endtask

  task automatic drain();
    for (int n = 0; n < 8; n++) begin
      if (pv[0] || pv[1] || pv[2] || pv[3]) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && wr_q.size() > 0) begin
      mon_e = wr_q.pop_front();
      chk("reg_write0", 64'(bus.reg_write0), 64'(mon_e.we0));
      chk("reg_write1", 64'(bus.reg_write1), 64'(mon_e.we1));
      chk("rr_ptr", 64'(rr_ptr), 64'(mon_e.rr));
      if (mon_e.we0) begin
        chk("dest0", 64'(bus.dest0), 64'(mon_e.d0));
        chk("word0", 64'(bus.word0), 64'(mon_e.w0));
      end
      if (mon_e.we1) begin
        chk("dest1", 64'(bus.dest1), 64'(mon_e.d1));
        chk("word1", 64'(bus.word1), 64'(mon_e.w1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rdy_q.size() > 0) begin
      mon_r = rdy_q.pop_front();
      chk("req_ready", 64'(bus.req_ready), 64'(mon_r));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    m_rr  = 0;
    for (int i = 0; i < N; i++) req(i, 5 + i, W'(32'hA0 + i));
    drive();
    #12;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_we0", 64'(bus.reg_write0), 64'h0);
    chk("rst_we1", 64'(bus.reg_write1), 64'h0);
    chk("rst_dest0", 64'(bus.dest0), 64'h0);
    chk("rst_word1", 64'(bus.word1), 64'h0);
    chk("rst_rr", 64'(rr_ptr), 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Round-robin: all four continuously valid with distinct destinations.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) req(i, 5 + i, W'($urandom));
      step(1'b0, 1'b0);
    end
    drain();

    // Same-destination conflict.
    req(0, 9, 32'h11);
    req(1, 9, 32'h22);
    req(2, 10, 32'h33);
    drain();

    // Destination zero consumes a grant without writing.
    req(3, 0, 32'hDEAD);
    drain();

    // Stall, then flush with stall, then release.
    req(0, 12, 32'h1234);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    drain();

    // Asynchronous reset while a write is being driven.
    req(0, 20, 32'hCAFE);
    step(1'b0, 1'b0);
    chk("pre_rst_we0", 64'(bus.reg_write0), 64'h1);
    #1;
    rst_n = 1'b0;
    wr_q  = {};
    rdy_q = {};
    #1;
    chk("async_we0", 64'(bus.reg_write0), 64'h0);
    chk("async_dest0", 64'(bus.dest0), 64'h0);
    chk("async_rr", 64'(rr_ptr), 64'h0);
    for (int i = 0; i < N; i++) req(i, i + 1, W'(i));
    drive();
    #1;
    chk("async_ready", 64'(bus.req_ready), 64'h0);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    drive();
    @(posedge clk);
    #2;
    m_rr  = 0;
    rst_n = 1'b1;

    // Randomized traffic with a small destination range to provoke conflicts.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) req(i, $urandom_range(0, 11), W'($urandom));
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    drain();

    @(posedge clk);
    #3;
    chk("wr_q_drained", 64'(wr_q.size()), 64'h0);
    chk("rdy_q_drained", 64'(rdy_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
